// File: rtl/fir_decim_buffer_if.sv
// rtl/fir_decim_buffer_if.sv - output sample stream of the decimating FIR buffer
//
// Purpose: groups the consumer-side valid/ready handshake into one bundle.
// Signals:
//   m_data  - sample at the FIFO head (WIDTH bits)
//   m_valid - m_data holds a valid sample
//   m_ready - consumer accepts m_data this cycle
// Modports:
//   master - producer side (drives m_data/m_valid, samples m_ready)
//   slave  - consumer side (samples m_data/m_valid, drives m_ready)

interface fir_decim_buffer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fir_decim_buffer.sv
// rtl/fir_decim_buffer.sv - runtime decimator with FWFT sample FIFO behind the FIR
//
// Purpose: keeps one of every R FIR output samples (R = i_decim, 0 means 1),
// stores kept samples in a first-word-fall-through circular FIFO and hands
// them to the consumer over a valid/ready handshake. Drops on overflow are
// recorded in a sticky flag.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-high reset
//   i_en       - i_fir_out carries a new sample this cycle
//   i_decim    - decimation factor R (RW bits)
//   i_fir_out  - FIR output sample (WIDTH bits)
//   i_clr_ovf  - synchronous clear of o_overflow
//   o_level    - FIFO occupancy 0..DEPTH
//   o_overflow - sticky: at least one kept sample was dropped
//   m_if       - output stream (m_data/m_valid/m_ready)

module fir_decim_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int RW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic [RW-1:0]          i_decim,
  input  logic [WIDTH-1:0]       i_fir_out,
  input  logic                   i_clr_ovf,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow,
  fir_decim_buffer_if.master     m_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [RW-1:0]    r_phase;
  logic [RW-1:0]    r_cur;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic [RW-1:0]    w_r_eff;
  logic [RW-1:0]    w_period;
  logic [RW-1:0]    w_phase_next;
  logic             w_boundary;
  logic             w_keep;
  logic             w_valid;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // ---------------------------------------------------------------------------
  // Decimation phase
  // ---------------------------------------------------------------------------
  assign w_r_eff    = (i_decim == '0) ? RW'(1) : i_decim;
  assign w_boundary = (r_phase == '0);
  assign w_keep     = i_en && w_boundary;

  // At a period boundary the freshly latched factor governs the period that
  // starts now, so the wrap decision uses it instead of the stale r_cur.
  assign w_period = w_boundary ? w_r_eff : r_cur;

  always_comb begin
    w_phase_next = '0;
    if (i_en && (r_phase != (w_period - RW'(1)))) begin
      w_phase_next = r_phase + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
      r_cur   <= RW'(1);
    end else begin
      r_phase <= w_phase_next;
      if (w_boundary) begin
        r_cur <= w_r_eff;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == FULL_COUNT);
  assign w_pop   = w_valid && m_if.m_ready;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_push  = w_keep && (!w_full || w_pop);
  assign w_drop  = w_keep && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_fir_out;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Set beats clear when a drop and clr_ovf coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: m_valid and m_data depend on registers only, never on m_ready.
  // ---------------------------------------------------------------------------
  assign m_if.m_valid = w_valid;
  assign m_if.m_data  = r_mem[r_rd_ptr];
  assign o_level      = r_count;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// tb/tb_fir_decim_buffer.sv - self-checking bench for fir_decim_buffer

module tb_fir_decim_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int RW    = 8;

  logic             clk;
  logic             rst;
  logic             i_en;
  logic [RW-1:0]    i_decim;
  logic [WIDTH-1:0] i_fir_out;
  logic             i_clr_ovf;
  logic [3:0]       o_level;
  logic             o_overflow;

  fir_decim_buffer_if #(.WIDTH(WIDTH)) bus ();

  fir_decim_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RW(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_decim    (i_decim),
    .i_fir_out  (i_fir_out),
    .i_clr_ovf  (i_clr_ovf),
    .o_level    (o_level),
    .o_overflow (o_overflow),
    .m_if       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Behavioural model: a queue of stored samples, a countdown of samples
  // still to skip before the next kept one, and the sticky overflow bit.
  logic [WIDTH-1:0] q[$];
  int               skip_left = 0;
  bit               m_ovf = 1'b0;

  // Samples the DUT actually handed over (captured on accepted handshakes).
  logic [WIDTH-1:0] got[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      cmp("m_valid", 32'(bus.m_valid), 32'(q.size() != 0));
      cmp("level", 32'(o_level), 32'(q.size()));
      cmp("overflow", 32'(o_overflow), 32'(m_ovf));
      if (q.size() != 0) cmp("m_data", 32'(bus.m_data), 32'(q[0]));
    end
  end

  // One clock of stimulus; called and returns at a negedge.
  task automatic cyc(input logic en, input logic [RW-1:0] dec, input logic [WIDTH-1:0] din,
                     input logic rdy, input logic clr);
    bit pop, keep, drop;
    int r;
    i_en = en; i_decim = dec; i_fir_out = din; bus.m_ready = rdy; i_clr_ovf = clr;
    #1;
    if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
    pop  = (q.size() != 0) && rdy;
    keep = en && (skip_left == 0);
    drop = 1'b0;
    if (!en) skip_left = 0;
    else if (keep) begin
      r = (dec == 0) ? 1 : int'(dec);
      skip_left = r - 1;
    end else skip_left--;
    if (pop) void'(q.pop_front());
    if (keep) begin
      if (q.size() < DEPTH) q.push_back(din);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_en = 1'b0; i_clr_ovf = 1'b0; bus.m_ready = 1'b0;
    q.delete(); skip_left = 0; m_ovf = 1'b0;
    #1;
    cmp("rst_m_valid", 32'(bus.m_valid), 32'd0);
    cmp("rst_level", 32'(o_level), 32'd0);
    cmp("rst_overflow", 32'(o_overflow), 32'd0);
    cmp("rst_m_data", 32'(bus.m_data), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, RW'(1), '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; i_en = 1'b0; i_decim = '0; i_fir_out = '0; i_clr_ovf = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    do_reset();
    chk_on = 1'b1;

    // R=4, free-flowing consumer: kept indices 0,4,8,12
    got.delete();
    for (int i = 0; i < 16; i++) cyc(1'b1, RW'(4), WIDTH'(i), 1'b1, 1'b0);
    flush(3);
    cmp("r4_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) cmp("r4_value", 32'(got[i]), 32'(i * 4));

    // decim=0 behaves as R=1
    got.delete();
    for (int i = 0; i < 5; i++) cyc(1'b1, RW'(0), WIDTH'(200 + i), 1'b1, 1'b0);
    flush(2);
    cmp("r0_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) cmp("r0_value", 32'(got[i]), 32'(200 + i));

    // R=3 then decim=5 from phase 1: kept 0,3,8,13
    got.delete();
    for (int i = 0; i < 16; i++) cyc(1'b1, (i == 0) ? RW'(3) : RW'(5), WIDTH'(i), 1'b1, 1'b0);
    flush(3);
    cmp("chg_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      cmp("chg_v0", 32'(got[0]), 32'd0);
      cmp("chg_v1", 32'(got[1]), 32'd3);
      cmp("chg_v2", 32'(got[2]), 32'd8);
      cmp("chg_v3", 32'(got[3]), 32'd13);
    end

    // Backpressure: 10 samples into 8 slots
    got.delete();
    for (int i = 0; i < 10; i++) cyc(1'b1, RW'(1), WIDTH'(100 + i), 1'b0, 1'b0);
    cmp("bp_level", 32'(o_level), 32'd8);
    cmp("bp_head", 32'(bus.m_data), 32'd100);
    cmp("bp_overflow", 32'(o_overflow), 32'd1);
    for (int i = 0; i < 10; i++) cyc(1'b0, RW'(1), '0, 1'b1, 1'b0);
    cmp("bp_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) cmp("bp_value", 32'(got[i]), 32'(100 + i));
    cmp("bp_empty", 32'(bus.m_valid), 32'd0);

    // Reset mid-run with 3 samples held and overflow still set
    for (int i = 0; i < 3; i++) cyc(1'b1, RW'(1), WIDTH'(500 + i), 1'b0, 1'b0);
    cmp("pre_rst_level", 32'(o_level), 32'd3);
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b0, RW'(1), WIDTH'(600 + i), 1'b0, 1'b0);
    cmp("idle_level", 32'(o_level), 32'd0);

    // Overflow clear, then clear colliding with a drop
    for (int i = 0; i < 9; i++) cyc(1'b1, RW'(1), WIDTH'(400 + i), 1'b0, 1'b0);
    cmp("ovf_set", 32'(o_overflow), 32'd1);
    cyc(1'b0, RW'(1), '0, 1'b0, 1'b1);
    cmp("ovf_clr", 32'(o_overflow), 32'd0);
    cyc(1'b1, RW'(1), WIDTH'(499), 1'b0, 1'b1);
    cmp("ovf_set_wins", 32'(o_overflow), 32'd1);
    flush(10);
    cyc(1'b0, RW'(1), '0, 1'b0, 1'b1);

    // Full FIFO with simultaneous pop and push
    got.delete();
    for (int i = 0; i < 8; i++) cyc(1'b1, RW'(1), WIDTH'(300 + i), 1'b0, 1'b0);
    for (int i = 8; i < 20; i++) cyc(1'b1, RW'(1), WIDTH'(300 + i), 1'b1, 1'b0);
    cmp("fp_level", 32'(o_level), 32'd8);
    cmp("fp_overflow", 32'(o_overflow), 32'd0);
    flush(10);
    cmp("fp_count", 32'(got.size()), 32'd20);
    for (int i = 0; i < 20 && i < got.size(); i++) cmp("fp_value", 32'(got[i]), 32'(300 + i));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), RW'($urandom_range(0, 5)), WIDTH'($urandom),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end
    flush(10);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_decim_buffer.md
Name: fir_decim_buffer

Overview:
- Downstream stage of the FIR filter. Consumes the filter output, which is valid every clock.
- Decimates the sample stream by a runtime-programmable factor and buffers the kept samples in a small FIFO.
- Delivers kept samples to the consumer (DMA/packetizer) over a valid/ready handshake.
- Flags samples dropped on FIFO overflow with a sticky bit.

Parameters:
- WIDTH, 16, sample width; must match the FIR output width.
- DEPTH, 8, FIFO depth in samples; power of 2, ≥2.
- RW, 8, width of the decimation-factor input.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  stream enable; when 1, fir_out is a new sample this cycle
- decim  in  RW  decimation factor R; 0 is treated as 1
- fir_out  in  WIDTH  FIR filter output sample
- m_data  out  WIDTH  output sample (FIFO head)
- m_valid  out  1  m_data holds a valid sample
- m_ready  in  1  consumer accepts m_data this cycle
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: at least one kept sample was dropped
- clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (async, rst=1): phase=0, r_cur=1, FIFO empty, m_valid=0, m_data=0, level=0, overflow=0. Reset takes effect immediately, including mid-stream; FIFO contents are discarded.
- Phase counter:
  - Range 0..r_cur-1.
  - When en=1: phase==0 marks a keep cycle; phase increments and wraps to 0 after r_cur-1.
  - When en=0: phase is forced to 0 and no sample is kept.
- Factor latch: r_cur loads max(decim,1) on every cycle where phase==0 (keep cycle or en=0). A decim change mid-period takes effect at the next period boundary, never mid-period.
- Keep: on a keep cycle, fir_out is presented as a write to the FIFO.
- Pop: fires when m_valid && m_ready.
- Write/full rules:
  - Write while FIFO not full: accepted.
  - Write while full with a simultaneous pop: accepted; level unchanged.
  - Write while full with no pop: sample dropped, overflow<=1, FIFO unchanged.
- FIFO mechanics:
  - Circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Count register 0..DEPTH; full when count==DEPTH, empty when count==0.
- Output, first-word fall-through:
  - m_valid = (count!=0); m_data = mem[rd_ptr], driven combinationally from the registered array.
  - Latency: a sample kept in cycle N is visible on m_data/m_valid in cycle N+1 if the FIFO was empty.
- Handshake:
  - m_data is stable while m_valid=1 and m_ready=0.
  - m_ready while m_valid=0 has no effect.
  - No combinational path from m_ready to m_valid.
- level = count; it updates on the cycle after each push/pop.
- overflow:
  - Set on a drop; cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, overflow=1 (set wins).
- Arithmetic: samples are passed through unmodified (no rounding or sign handling); stored bit-exact.
- Simultaneous push and pop with count in 1..DEPTH-1: both pointers advance, count unchanged.
- Simultaneous push and pop with count==0: no pop is possible (m_valid=0); the push lands, and m_valid=1 next cycle.

Test Plan:
- Reset/idle: assert rst mid-run with FIFO holding 3 samples → m_valid=0, level=0, overflow=0 immediately; after release with en=0, nothing is written.
- Decimation R=4, m_ready=1, fir_out = cycle index 0,1,2… with en=1 from index 0 → outputs 0,4,8,12; each appears one cycle after its keep cycle; decim=0 case → every sample output (R=1).
- Factor change: R=3, change decim to 5 at phase 1 → kept indices 0,3,8,13 (new R applied only at the boundary).
- Backpressure/full: DEPTH=8, R=1, m_ready=0 for 10 samples 100..109 → level=8, m_data=100, overflow=1, samples 108,109 dropped; then m_ready=1 → outputs 100..107 in order, m_valid falls after the 8th.
- Full with simultaneous pop: FIFO full, m_ready=1, en=1, R=1 → level stays 8, no overflow, output order preserved.
- Overflow clear: overflow=1, pulse clr_ovf with no drop → 0; pulse clr_ovf in the same cycle as a drop → remains 1.
